// File: rtl/connect4_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : connect4_pkg                                                 |
// | Description : Board geometry, cell/direction/state types, index helpers.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package connect4_pkg;

    localparam int FILAS      = 6;
    localparam int COLUMNAS   = 7;
    localparam int NUM_CELDAS = FILAS * COLUMNAS;
    localparam int NUM_CHECKS = NUM_CELDAS * 4;
    localparam int TAB_W      = NUM_CELDAS * 2;

    typedef enum logic [1:0] {
        VACIA    = 2'b00,
        JUG1     = 2'b01,
        JUG2     = 2'b10,
        INVALIDA = 2'b11
    } celda_t;

    typedef enum logic [1:0] {
        DIR_COL      = 2'd0,
        DIR_FILA     = 2'd1,
        DIR_DIAG_SUB = 2'd2,
        DIR_DIAG_BAJ = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        FIN  = 2'd2
    } estado_t;

    // Returns {fila, col}; row chosen by threshold compares instead of a divider.
    function automatic logic [5:0] idx_a_pos(input logic [5:0] idx);
        logic [2:0] fila;
        logic [5:0] resto;
        fila = 3'd0;
        for (int f = 1; f < FILAS; f++) begin
            if (idx >= 6'(f * COLUMNAS)) begin
                fila = 3'(f);
            end
        end
        resto = idx - 6'({3'b000, fila} * 6'(COLUMNAS));
        return {fila, resto[2:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/connect4_line_check.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : connect4_line_check                                          |
// | Description : Combinational test of one four-cell line from a start cell.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module connect4_line_check
    import connect4_pkg::*;
(
    input  logic [TAB_W-1:0] tablero,
    input  logic [2:0]       fila,
    input  logic [2:0]       col,
    input  dir_t             dir,
    output logic             hit,
    output logic [1:0]       jugador
);

    // Padded to 64 entries so wrapped indices of out-of-bounds lines stay legal.
    logic [1:0] w_celdas [64];

    genvar gi;
    generate
        for (gi = 0; gi < 64; gi++) begin : g_celdas
            if (gi < NUM_CELDAS) begin : g_valida
                assign w_celdas[gi] = tablero[2*gi +: 2];
            end else begin : g_relleno
                assign w_celdas[gi] = 2'b00;
            end
        end
    endgenerate

    logic [5:0] w_base;
    logic [5:0] w_paso;
    logic [5:0] w_i1;
    logic [5:0] w_i2;
    logic [5:0] w_i3;
    logic       w_en_rango;
    logic [1:0] w_v0;
    logic [1:0] w_v1;
    logic [1:0] w_v2;
    logic [1:0] w_v3;
    logic       w_col_ok;

    assign w_base   = 6'({3'b000, fila} * 6'(COLUMNAS)) + {3'b000, col};
    assign w_col_ok = (col <= 3'(COLUMNAS - 4));

    always_comb begin
        w_paso     = 6'd1;
        w_en_rango = 1'b0;
        case (dir)
            DIR_COL: begin
                w_paso     = 6'd1;
                w_en_rango = w_col_ok;
            end
            DIR_FILA: begin
                w_paso     = 6'(COLUMNAS);
                w_en_rango = (fila <= 3'(FILAS - 4));
            end
            DIR_DIAG_SUB: begin
                w_paso     = 6'(COLUMNAS + 1);
                w_en_rango = w_col_ok && (fila <= 3'(FILAS - 4));
            end
            DIR_DIAG_BAJ: begin
                // Step of -(COLUMNAS-1) in 6-bit modular arithmetic
                w_paso     = 6'(64 - (COLUMNAS - 1));
                w_en_rango = w_col_ok && (fila >= 3'd3);
            end
            default: begin
                w_paso     = 6'd1;
                w_en_rango = 1'b0;
            end
        endcase
    end

    assign w_i1 = w_base + w_paso;
    assign w_i2 = w_i1 + w_paso;
    assign w_i3 = w_i2 + w_paso;

    assign w_v0 = w_celdas[w_base];
    assign w_v1 = w_celdas[w_i1];
    assign w_v2 = w_celdas[w_i2];
    assign w_v3 = w_celdas[w_i3];

    assign hit = w_en_rango
              && (w_v0 == w_v1) && (w_v1 == w_v2) && (w_v2 == w_v3)
              && ((w_v0 == JUG1) || (w_v0 == JUG2));
    assign jugador = hit ? w_v0 : 2'b00;

endmodule
`default_nettype wire

// File: rtl/connect4_win_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : connect4_win_checker                                         |
// | Description : Sequential Connect 4 win/draw scanner, one check per clock.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module connect4_win_checker
    import connect4_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [TAB_W-1:0] tablero,
    input  logic             start,
    input  logic             nuevo_juego,
    output logic             busy,
    output logic             done,
    output logic             fin_juego,
    output logic             empate,
    output logic [2:0]       columna,
    output logic [1:0]       ganador
);

    localparam logic [7:0] C_K_ULTIMO = 8'(NUM_CHECKS - 1);

    estado_t          r_estado;
    estado_t          w_estado_sig;
    logic [7:0]       r_k;
    logic [TAB_W-1:0] r_snap;
    logic             r_busy;
    logic             r_done;
    logic             r_fin;
    logic             r_empate;
    logic [2:0]       r_columna;
    logic [1:0]       r_ganador;

    logic [5:0] w_pos;
    logic [2:0] w_fila;
    logic [2:0] w_col;
    dir_t       w_dir;
    logic       w_hit;
    logic [1:0] w_jugador;
    logic       w_lleno;
    logic       w_captura;
    logic       w_inc;
    logic       w_latch_win;
    logic       w_latch_empate;

    assign w_pos  = idx_a_pos(r_k[7:2]);
    assign w_fila = w_pos[5:3];
    assign w_col  = w_pos[2:0];
    assign w_dir  = dir_t'(r_k[1:0]);

    connect4_line_check u_line_check (
        .tablero (r_snap),
        .fila    (w_fila),
        .col     (w_col),
        .dir     (w_dir),
        .hit     (w_hit),
        .jugador (w_jugador)
    );

    // Full board: no cell reads as empty (00 or the invalid 11 code).
    always_comb begin
        w_lleno = 1'b1;
        for (int i = 0; i < NUM_CELDAS; i++) begin
            if ((r_snap[2*i +: 2] == VACIA) || (r_snap[2*i +: 2] == INVALIDA)) begin
                w_lleno = 1'b0;
            end
        end
    end

    always_comb begin
        w_estado_sig   = r_estado;
        w_captura      = 1'b0;
        w_inc          = 1'b0;
        w_latch_win    = 1'b0;
        w_latch_empate = 1'b0;
        if (nuevo_juego) begin
            w_estado_sig = IDLE;
        end else begin
            case (r_estado)
                IDLE: begin
                    if (start && !r_fin && !r_empate) begin
                        w_captura    = 1'b1;
                        w_estado_sig = SCAN;
                    end
                end
                SCAN: begin
                    if (w_hit) begin
                        w_latch_win  = 1'b1;
                        w_estado_sig = FIN;
                    end else if (r_k == C_K_ULTIMO) begin
                        w_latch_empate = w_lleno;
                        w_estado_sig   = FIN;
                    end else begin
                        w_inc = 1'b1;
                    end
                end
                FIN:     w_estado_sig = IDLE;
                default: w_estado_sig = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado  <= IDLE;
            r_k       <= 8'd0;
            r_snap    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_fin     <= 1'b0;
            r_empate  <= 1'b0;
            r_columna <= 3'd0;
            r_ganador <= 2'b00;
        end else begin
            r_estado <= w_estado_sig;
            // Busy/done follow the next state so they are flops, not state decodes
            r_busy   <= (w_estado_sig != IDLE);
            r_done   <= (w_estado_sig == FIN);
            if (w_captura) begin
                r_snap <= tablero;
                r_k    <= 8'd0;
            end else if (w_inc) begin
                r_k <= r_k + 8'd1;
            end
            if (nuevo_juego) begin
                r_fin     <= 1'b0;
                r_empate  <= 1'b0;
                r_columna <= 3'd0;
                r_ganador <= 2'b00;
            end else begin
                if (w_latch_win) begin
                    r_fin     <= 1'b1;
                    r_columna <= w_col;
                    r_ganador <= w_jugador;
                end
                if (w_latch_empate) begin
                    r_empate <= 1'b1;
                end
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign fin_juego = r_fin;
    assign empate    = r_empate;
    assign columna   = r_columna;
    assign ganador   = r_ganador;

endmodule
`default_nettype wire

// File: tb/tb_connect4_win_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_connect4_win_checker                                      |
// | Description : Directed self-checking bench for connect4_win_checker.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_connect4_win_checker;

    logic        clk;
    logic        rst;
    logic [83:0] tablero;
    logic        start;
    logic        nuevo_juego;
    logic        busy;
    logic        done;
    logic        fin_juego;
    logic        empate;
    logic [2:0]  columna;
    logic [1:0]  ganador;

    int n_pass;
    int n_total;
    int ciclo;

    connect4_win_checker dut (
        .clk         (clk),
        .rst         (rst),
        .tablero     (tablero),
        .start       (start),
        .nuevo_juego (nuevo_juego),
        .busy        (busy),
        .done        (done),
        .fin_juego   (fin_juego),
        .empate      (empate),
        .columna     (columna),
        .ganador     (ganador)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chk_out(input string tag, input logic eb, input logic ed, input logic ef,
                           input logic ee, input logic [2:0] ec, input logic [1:0] eg);
        chk({tag, "/busy"},      8'(busy),      8'(eb));
        chk({tag, "/done"},      8'(done),      8'(ed));
        chk({tag, "/fin_juego"}, 8'(fin_juego), 8'(ef));
        chk({tag, "/empate"},    8'(empate),    8'(ee));
        chk({tag, "/columna"},   8'(columna),   8'(ec));
        chk({tag, "/ganador"},   8'(ganador),   8'(eg));
    endtask

    task automatic poner(input int f, input int c, input logic [1:0] v);
        tablero[2*(f*7+c) +: 2] = v;
    endtask

    task automatic tab_horizontal();
        tablero = '0;
        for (int c = 2; c <= 5; c++) poner(0, c, 2'b01);
    endtask

    task automatic tab_diagonal();
        tablero = '0;
        poner(3, 0, 2'b10);
        poner(2, 1, 2'b10);
        poner(1, 2, 2'b10);
        poner(0, 3, 2'b10);
    endtask

    // Called at a negedge; returns at the negedge of cycle 1 of the scan.
    task automatic pulso_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ciclo = 1;
    endtask

    task automatic esperar(input int objetivo);
        while (ciclo < objetivo) begin
            @(negedge clk);
            ciclo++;
        end
    endtask

    task automatic pulso_nuevo();
        nuevo_juego = 1'b1;
        @(negedge clk);
        nuevo_juego = 1'b0;
    endtask

    initial begin
        n_pass      = 0;
        n_total     = 0;
        ciclo       = 0;
        rst         = 1'b1;
        tablero     = '0;
        start       = 1'b0;
        nuevo_juego = 1'b0;
        repeat (3) @(negedge clk);
        chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'b00);
        rst = 1'b0;
        @(negedge clk);

        // Horizontal win: hit at k=8, done in cycle 10
        tab_horizontal();
        pulso_start();
        chk("horiz_c1/busy", 8'(busy), 8'd1);
        esperar(9);
        chk_out("horiz_c9", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'b00);
        esperar(10);
        chk_out("horiz_c10", 1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 2'b01);
        esperar(11);
        chk_out("horiz_c11", 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 2'b01);
        pulso_start();
        chk("horiz_start_ignored/busy", 8'(busy), 8'd0);

        // Reset while a win is latched
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_out("reset_fin", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'b00);

        // Diagonal win: cell 21 dir 3, k=87, done in cycle 89
        tab_diagonal();
        pulso_start();
        esperar(88);
        chk_out("diag_c88", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'b00);
        esperar(89);
        chk_out("diag_c89", 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 2'b10);
        pulso_nuevo();
        chk_out("diag_nuevo", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'b00);

        // Vertical win at column 6 with a row of invalid 11 codes below it
        tablero = '0;
        for (int c = 0; c < 4; c++) poner(0, c, 2'b11);
        for (int f = 2; f < 6; f++) poner(f, 6, 2'b01);
        pulso_start();
        esperar(82);
        chk("vert_c82/done", 8'(done), 8'd0);
        esperar(83);
        chk_out("vert_c83", 1'b1, 1'b1, 1'b1, 1'b0, 3'd6, 2'b01);
        pulso_nuevo();

        // No win, board not full
        tablero = '0;
        for (int c = 0; c < 3; c++) poner(0, c, 2'b01);
        pulso_start();
        esperar(168);
        chk_out("nowin_c168", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'b00);
        esperar(169);
        chk_out("nowin_c169", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 2'b00);
        esperar(170);
        chk_out("nowin_c170", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'b00);

        // Second start accepted; abort at cycle 50 with a simultaneous start
        pulso_start();
        chk("restart_c1/busy", 8'(busy), 8'd1);
        esperar(50);
        nuevo_juego = 1'b1;
        start       = 1'b1;
        @(negedge clk);
        nuevo_juego = 1'b0;
        start       = 1'b0;
        chk_out("abort_c51", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'b00);
        @(negedge clk);
        chk("abort_c52/busy", 8'(busy), 8'd0);
        chk("abort_c52/done", 8'(done), 8'd0);

        // Restart on the diagonal board; the live board changes mid-scan
        tab_diagonal();
        pulso_start();
        esperar(5);
        tab_horizontal();
        esperar(10);
        chk("snap_c10/done", 8'(done), 8'd0);
        esperar(89);
        chk_out("snap_c89", 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 2'b10);
        pulso_nuevo();

        // Draw: full board, no line (player = col[1] xor fila[0])
        tablero = '0;
        for (int f = 0; f < 6; f++) begin
            for (int c = 0; c < 7; c++) begin
                poner(f, c, (((c >> 1) & 1) ^ (f & 1)) != 0 ? 2'b10 : 2'b01);
            end
        end
        pulso_start();
        esperar(168);
        chk("draw_c168/empate", 8'(empate), 8'd0);
        esperar(169);
        chk_out("draw_c169", 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 2'b00);
        esperar(170);
        chk_out("draw_c170", 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 2'b00);
        pulso_start();
        chk("draw_start_ignored/busy", 8'(busy), 8'd0);
        pulso_nuevo();
        chk("draw_nuevo/empate", 8'(empate), 8'd0);

        // Reset during a scan
        tab_diagonal();
        pulso_start();
        esperar(30);
        chk("rst_scan_c30/busy", 8'(busy), 8'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_out("rst_scan", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'b00);
        @(negedge clk);
        chk("rst_scan_idle/busy", 8'(busy), 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
